// File: rtl/simd_sequencer.sv
// Start/done program controller for the SIMD processor: fetch, latch, fixed-length
// execute and a single write-back strobe per instruction, ending on length or HALT.
module simd_sequencer #(
    parameter int INS_ADDR_WIDTH = 10,
    parameter int ADDR_WIDTH     = 10,
    parameter int OPCODE_WIDTH   = 3,
    parameter int EXEC_CYCLES    = 2,
    parameter logic [OPCODE_WIDTH-1:0] HALT_OP = {OPCODE_WIDTH{1'b1}}
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic                                  abort,
    input  logic [INS_ADDR_WIDTH:0]               prog_len,
    input  logic [OPCODE_WIDTH+3*ADDR_WIDTH-1:0]  instruction,
    output logic [INS_ADDR_WIDTH-1:0]             pc,
    output logic                                  ins_rd_en,
    output logic [OPCODE_WIDTH+3*ADDR_WIDTH-1:0]  ir,
    output logic                                  exec_en,
    output logic                                  wb_strobe,
    output logic                                  busy,
    output logic                                  done,
    output logic [31:0]                           cycle_cnt
);

    localparam int IW = OPCODE_WIDTH + 3 * ADDR_WIDTH;
    localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CW-1:0] EXEC_LOAD = CW'(EXEC_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_EXEC,
        S_WB,
        S_DONE
    } state_t;

    state_t                    state_reg;
    state_t                    state_next;
    logic [INS_ADDR_WIDTH:0]   prog_len_reg;
    logic [INS_ADDR_WIDTH-1:0] pc_reg;
    logic [IW-1:0]             ir_reg;
    logic [CW-1:0]             exec_cnt_reg;
    logic                      ins_rd_en_reg;
    logic                      exec_en_reg;
    logic                      wb_strobe_reg;
    logic                      busy_reg;
    logic                      done_reg;
    logic [31:0]               cycle_cnt_reg;

    logic                      start_ok;
    logic                      halt_hit;
    logic                      last_ins;
    logic [INS_ADDR_WIDTH:0]   pc_inc;

    assign start_ok = (state_reg == S_IDLE) && start && !abort;
    assign halt_hit = (instruction[IW-1 -: OPCODE_WIDTH] == HALT_OP);
    // Compared one bit wider so a full-memory program ends at pc all-ones instead of wrapping.
    assign pc_inc   = {1'b0, pc_reg} + (INS_ADDR_WIDTH+1)'(1);
    assign last_ins = (pc_inc == prog_len_reg);

    always_comb begin
        state_next = state_reg;
        if (abort) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE:  if (start) state_next = (prog_len == '0) ? S_DONE : S_FETCH;
                S_FETCH: state_next = S_LATCH;
                S_LATCH: state_next = halt_hit ? S_DONE : S_EXEC;
                S_EXEC:  if (exec_cnt_reg == '0) state_next = S_WB;
                S_WB:    state_next = last_ins ? S_DONE : S_FETCH;
                S_DONE:  state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            prog_len_reg  <= '0;
            pc_reg        <= '0;
            ir_reg        <= '0;
            exec_cnt_reg  <= '0;
            ins_rd_en_reg <= 1'b0;
            exec_en_reg   <= 1'b0;
            wb_strobe_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            cycle_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            // Output flags follow the state being entered, so they stay glitch-free registers.
            ins_rd_en_reg <= (state_next == S_FETCH);
            exec_en_reg   <= (state_next == S_EXEC);
            wb_strobe_reg <= (state_next == S_WB);
            done_reg      <= (state_next == S_DONE);
            busy_reg      <= (state_next != S_IDLE);

            if (start_ok) begin
                prog_len_reg  <= prog_len;
                pc_reg        <= '0;
                cycle_cnt_reg <= '0;
            end else if (busy_reg && (cycle_cnt_reg != '1)) begin
                cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
            end

            if (!abort) begin
                case (state_reg)
                    S_LATCH: begin
                        ir_reg       <= instruction;
                        exec_cnt_reg <= EXEC_LOAD;
                    end
                    S_EXEC: begin
                        if (exec_cnt_reg != '0) exec_cnt_reg <= exec_cnt_reg - CW'(1);
                    end
                    S_WB: begin
                        if (!last_ins) pc_reg <= pc_inc[INS_ADDR_WIDTH-1:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign pc        = pc_reg;
    assign ins_rd_en = ins_rd_en_reg;
    assign ir        = ir_reg;
    assign exec_en   = exec_en_reg;
    assign wb_strobe = wb_strobe_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign cycle_cnt = cycle_cnt_reg;

endmodule

// File: tb/tb_simd_sequencer.sv
// Bench for simd_sequencer: expected per-cycle traces built from the program rules,
// plus directed reset, abort and boundary checks on three parameterisations.
module tb_simd_sequencer;

    localparam int IW = 33;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]    start_v    = '0;
    logic          abort      = 1'b0;
    logic [10:0]   prog_len_v = '0;
    logic [IW-1:0] mem [0:1023];
    int            sel        = 0;

    logic [9:0]    pc_0, pc_1;
    logic [3:0]    pc_2;
    logic          rd_0, rd_1, rd_2, ex_0, ex_1, ex_2, wb_0, wb_1, wb_2;
    logic          busy_0, busy_1, busy_2, done_0, done_1, done_2;
    logic [IW-1:0] ir_0, ir_1, ir_2, instr_0, instr_1, instr_2;
    logic [31:0]   cnt_0, cnt_1, cnt_2;

    simd_sequencer u_dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort), .prog_len(prog_len_v),
        .instruction(instr_0), .pc(pc_0), .ins_rd_en(rd_0), .ir(ir_0), .exec_en(ex_0),
        .wb_strobe(wb_0), .busy(busy_0), .done(done_0), .cycle_cnt(cnt_0)
    );

    simd_sequencer #(.EXEC_CYCLES(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort), .prog_len(prog_len_v),
        .instruction(instr_1), .pc(pc_1), .ins_rd_en(rd_1), .ir(ir_1), .exec_en(ex_1),
        .wb_strobe(wb_1), .busy(busy_1), .done(done_1), .cycle_cnt(cnt_1)
    );

    simd_sequencer #(.INS_ADDR_WIDTH(4)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort), .prog_len(prog_len_v[4:0]),
        .instruction(instr_2), .pc(pc_2), .ins_rd_en(rd_2), .ir(ir_2), .exec_en(ex_2),
        .wb_strobe(wb_2), .busy(busy_2), .done(done_2), .cycle_cnt(cnt_2)
    );

    // Instruction memories with one cycle of read latency.
    always @(posedge clk) begin
        if (rd_0) instr_0 <= mem[pc_0];
        if (rd_1) instr_1 <= mem[pc_1];
        if (rd_2) instr_2 <= mem[{6'd0, pc_2}];
    end

    int            a_rd, a_ex, a_wb, a_dn, a_busy, a_pc;
    longint        a_cnt;
    logic [IW-1:0] a_ir;

    always_comb begin
        a_rd = rd_0; a_ex = ex_0; a_wb = wb_0; a_dn = done_0; a_busy = busy_0;
        a_pc = int'(pc_0); a_cnt = longint'(cnt_0); a_ir = ir_0;
        if (sel == 1) begin
            a_rd = rd_1; a_ex = ex_1; a_wb = wb_1; a_dn = done_1; a_busy = busy_1;
            a_pc = int'(pc_1); a_cnt = longint'(cnt_1); a_ir = ir_1;
        end else if (sel == 2) begin
            a_rd = rd_2; a_ex = ex_2; a_wb = wb_2; a_dn = done_2; a_busy = busy_2;
            a_pc = int'(pc_2); a_cnt = longint'(cnt_2); a_ir = ir_2;
        end
    end

    typedef struct {
        int            rd;
        int            ex;
        int            wb;
        int            dn;
        int            busy;
        int            pc;
        int            cnt;
        int            ir_chk;
        logic [IW-1:0] ir;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int wb_seen = 0, done_seen = 0, rd_seen = 0, rd_pc0 = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic void push(input int rd, input int ex, input int wb, input int dn,
                                 input int bz, input int p, input int c, input int ic,
                                 input logic [IW-1:0] irv);
        exp_t e;
        e.rd = rd; e.ex = ex; e.wb = wb; e.dn = dn; e.busy = bz;
        e.pc = p; e.cnt = c; e.ir_chk = ic; e.ir = irv;
        q.push_back(e);
    endfunction

    // Expected trace: one IDLE cycle while start is sampled, then per instruction
    // fetch, latch, e execute cycles and write-back (halt stops after latch), then DONE.
    function automatic void build(input int n, input int e);
        int k = 0;
        int last = 0;
        push(0, 0, 0, 0, 0, -1, -1, 0, '0);
        for (int i = 0; i < n; i++) begin
            last = i;
            push(1, 0, 0, 0, 1, i, k, 0, '0); k++;
            push(0, 0, 0, 0, 1, i, k, 0, '0); k++;
            if (mem[i][IW-1 -: 3] == 3'b111) break;
            for (int j = 0; j < e; j++) begin
                push(0, 1, 0, 0, 1, i, k, 1, mem[i]); k++;
            end
            push(0, 0, 1, 0, 1, i, k, 1, mem[i]); k++;
        end
        push(0, 0, 0, 1, 1, last, k, (n > 0) ? 1 : 0, mem[last]); k++;
        push(0, 0, 0, 0, 0, last, k, (n > 0) ? 1 : 0, mem[last]);
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (a_wb != 0) wb_seen++;
            if (a_dn != 0) done_seen++;
            if (a_rd != 0) begin
                rd_seen++;
                if (a_pc == 0) rd_pc0++;
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ins_rd_en", a_rd, e.rd);
                chk("exec_en", a_ex, e.ex);
                chk("wb_strobe", a_wb, e.wb);
                chk("done", a_dn, e.dn);
                chk("busy", a_busy, e.busy);
                if (e.pc >= 0) chk("pc", a_pc, e.pc);
                if (e.cnt >= 0) chk("cycle_cnt", a_cnt, e.cnt);
                if (e.ir_chk != 0) chk("ir", a_ir, e.ir);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run(input int s, input int n, input int e, input bit pulses);
        sel = s;
        start_v[s] = 1'b1;
        prog_len_v = 11'(n);
        build(n, e);
        cyc(1);
        start_v[s] = 1'b0;
        prog_len_v = 11'h5a5;
        for (int t = 0; t < 400 && q.size() > 0; t++) begin
            if (pulses && t >= 3 && t < 9) start_v[s] = t[0];
            cyc(1);
        end
        start_v[s] = 1'b0;
        if (q.size() > 0) begin
            chk("run_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    int w, d, r, r0;

    initial begin
        for (int i = 0; i < 1024; i++)
            mem[i] = {3'(i % 7), 10'(i * 3), 10'(i + 5), 10'(1000 - i)};

        cyc(2);
        chk("rst_pc", pc_0, 0);
        chk("rst_ir", ir_0, 0);
        chk("rst_busy", busy_0, 0);
        chk("rst_cnt", cnt_0, 0);
        chk("rst_rd", rd_0, 0);
        chk("rst_done2", done_2, 0);
        rst = 1'b0;
        cyc(1);

        // Async reset in the middle of instruction 1's execute phase.
        start_v[0] = 1'b1; prog_len_v = 11'd3;
        cyc(1);
        start_v[0] = 1'b0;
        cyc(7);
        chk("pre_rst_exec", ex_0, 1);
        chk("pre_rst_pc", pc_0, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_exec", ex_0, 0);
        chk("mid_rst_busy", busy_0, 0);
        chk("mid_rst_pc", pc_0, 0);
        chk("mid_rst_ir", ir_0, 0);
        chk("mid_rst_cnt", cnt_0, 0);
        cyc(1);
        rst = 1'b0;
        cyc(1);

        w = wb_seen; d = done_seen;
        run(0, 3, 2, 0);
        chk("len3_cnt", cnt_0, 16);
        chk("len3_wb", wb_seen - w, 3);
        chk("len3_done", done_seen - d, 1);

        mem[1][IW-1 -: 3] = 3'b111;
        w = wb_seen; d = done_seen;
        run(0, 8, 2, 0);
        chk("halt_pc", pc_0, 1);
        chk("halt_wb", wb_seen - w, 1);
        chk("halt_done", done_seen - d, 1);
        chk("halt_cnt", cnt_0, 8);
        mem[1][IW-1 -: 3] = 3'b001;

        w = wb_seen; d = done_seen; r = rd_seen;
        run(0, 0, 2, 0);
        chk("len0_cnt", cnt_0, 1);
        chk("len0_rd", rd_seen - r, 0);
        chk("len0_wb", wb_seen - w, 0);
        chk("len0_done", done_seen - d, 1);

        // Abort in the second execute cycle of instruction 0.
        sel = 0;
        w = wb_seen; d = done_seen;
        start_v[0] = 1'b1; prog_len_v = 11'd3;
        cyc(1);
        start_v[0] = 1'b0;
        cyc(3);
        chk("abort_in_exec", ex_0, 1);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("abort_busy", busy_0, 0);
        chk("abort_exec", ex_0, 0);
        chk("abort_pc", pc_0, 0);
        cyc(3);
        chk("abort_wb", wb_seen - w, 0);
        chk("abort_done", done_seen - d, 0);
        chk("abort_cnt", cnt_0, 4);

        abort = 1'b1; start_v[0] = 1'b1;
        cyc(1);
        abort = 1'b0; start_v[0] = 1'b0;
        chk("abort_start_busy", busy_0, 0);
        chk("abort_start_cnt", cnt_0, 4);
        cyc(1);

        run(0, 3, 2, 1);
        chk("pulse_cnt", cnt_0, 16);

        w = wb_seen;
        run(1, 3, 4, 0);
        chk("e4_cnt", cnt_1, 22);
        chk("e4_wb", wb_seen - w, 3);

        w = wb_seen; d = done_seen; r0 = rd_pc0;
        run(2, 16, 2, 0);
        chk("full_cnt", cnt_2, 81);
        chk("full_pc", pc_2, 15);
        chk("full_wb", wb_seen - w, 16);
        chk("full_fetch_pc0", rd_pc0 - r0, 1);
        chk("full_done", done_seen - d, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
